// File: rtl/retro_bus_pkg.sv
// Shared types and constants for the bus delay controller.
// Holds the FSM state encoding and the counter-width helper.
package retro_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FAST,
    STALL,
    DONE
  } bus_delay_state_t;

  // A timed-out read leaves the last captured data on CoreRData.
  localparam bit OPEN_BUS_HOLD = 1'b1;

  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bus_delay_ctl_if.sv
// Core-side and memory-side signals of the bus delay controller.
// slave = the controller, master = the core/memory environment.
interface bus_delay_ctl_if #(
  parameter int AddrWidth = 24,
  parameter int DataWidth = 8
);

  logic                 CoreReq;
  logic                 CoreWe;
  logic [AddrWidth-1:0] CoreAddr;
  logic [DataWidth-1:0] CoreWData;
  logic [DataWidth-1:0] CoreRData;
  logic                 CoreDone;
  logic                 MemReq;
  logic                 MemWe;
  logic [AddrWidth-1:0] MemAddr;
  logic [DataWidth-1:0] MemWData;
  logic                 MemAck;
  logic [DataWidth-1:0] MemRData;

  modport slave (
    input  CoreReq, CoreWe, CoreAddr, CoreWData,
    input  MemAck, MemRData,
    output CoreRData, CoreDone,
    output MemReq, MemWe, MemAddr, MemWData
  );

  modport master (
    output CoreReq, CoreWe, CoreAddr, CoreWData,
    output MemAck, MemRData,
    input  CoreRData, CoreDone,
    input  MemReq, MemWe, MemAddr, MemWData
  );

endinterface

// File: rtl/bus_delay_ctl.sv
// Turns slow memory handshakes into the catch-up unit's Delay input.
// Define DELAY_STATS_EN to add the DelayCycles stall counter output.
module bus_delay_ctl
  import retro_bus_pkg::*;
#(
  parameter int AddrWidth   = 24,
  parameter int DataWidth   = 8,
  parameter int SlackCycles = 4,
  parameter int MaxWait     = 64
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            RefCe,
  bus_delay_ctl_if.slave  bus,
  output logic            Delay,
  output logic            Timeout
`ifdef DELAY_STATS_EN
  ,
  output logic [31:0]     DelayCycles
`endif
);

  localparam int SW = cnt_w(SlackCycles);
  localparam int WW = cnt_w(MaxWait);

  localparam logic [SW-1:0] SLACK_INIT = SW'(SlackCycles);
  localparam logic [SW-1:0] SLACK_LAST = SW'(1);
  localparam logic [WW-1:0] WAIT_LIM   = WW'(MaxWait);

  bus_delay_state_t state_q, state_d;

  logic [SW-1:0]        slack_q, slack_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
  logic                 delay_q, delay_d;
  logic                 timeout_q, timeout_d;
  logic                 core_done_q, core_done_d;
  logic [DataWidth-1:0] core_rdata_q, core_rdata_d;

  logic          ack;
  logic [SW-1:0] slack_dec;
  logic [WW-1:0] wait_inc;
  logic          timeout_hit;

  assign ack       = mem_req_q && bus.MemAck;
  assign slack_dec = (slack_q != '0) ? slack_q - SW'(1) : slack_q;
  assign wait_inc  = (wait_q != '1) ? wait_q + WW'(1) : wait_q;
  assign timeout_hit = (wait_inc >= WAIT_LIM);

  always_comb begin
    state_d      = state_q;
    slack_d      = slack_q;
    wait_d       = wait_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    delay_d      = delay_q;
    timeout_d    = 1'b0;
    core_done_d  = core_done_q;
    core_rdata_d = core_rdata_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (RefCe) begin
          if (bus.CoreReq) begin
            state_d     = WAIT_FAST;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.CoreWe;
            mem_addr_d  = bus.CoreAddr;
            mem_wdata_d = bus.CoreWData;
            slack_d     = SLACK_INIT;
            wait_d      = '0;
            core_done_d = 1'b0;
          end else begin
            state_d     = IDLE;
            core_done_d = 1'b0;
          end
        end
      end
      WAIT_FAST, STALL: begin
        slack_d = slack_dec;
        wait_d  = wait_inc;
        // An ack on the timeout edge still completes the transfer.
        if (ack) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          delay_d     = 1'b0;
          core_done_d = 1'b1;
          if (!mem_we_q) begin
            core_rdata_d = bus.MemRData;
          end
        end else if (timeout_hit) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          delay_d     = 1'b0;
          timeout_d   = 1'b1;
          core_done_d = 1'b1;
          if (!OPEN_BUS_HOLD) begin
            core_rdata_d = '0;
          end
        end else if (state_q == WAIT_FAST &&
                     slack_q == SLACK_LAST) begin
          state_d = STALL;
          delay_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      slack_q      <= '0;
      wait_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      delay_q      <= 1'b0;
      timeout_q    <= 1'b0;
      core_done_q  <= 1'b0;
      core_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      slack_q      <= slack_d;
      wait_q       <= wait_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      delay_q      <= delay_d;
      timeout_q    <= timeout_d;
      core_done_q  <= core_done_d;
      core_rdata_q <= core_rdata_d;
    end
  end

  assign bus.MemReq    = mem_req_q;
  assign bus.MemWe     = mem_we_q;
  assign bus.MemAddr   = mem_addr_q;
  assign bus.MemWData  = mem_wdata_q;
  assign bus.CoreDone  = core_done_q;
  assign bus.CoreRData = core_rdata_q;
  assign Delay         = delay_q;
  assign Timeout       = timeout_q;

`ifdef DELAY_STATS_EN
  logic [31:0] dcyc_q, dcyc_d;

  always_comb begin
    dcyc_d = dcyc_q;
    if (delay_q && dcyc_q != '1) begin
      dcyc_d = dcyc_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dcyc_q <= '0;
    end else begin
      dcyc_q <= dcyc_d;
    end
  end

  assign DelayCycles = dcyc_q;
`endif

endmodule
